// File: rtl/bitfusion_psum_accum.sv
// bitfusion_psum_accum: sign-extends fused psum lanes, accumulates them across K-tiles,
// and queues each finished group in a small output FIFO.
module bitfusion_psum_accum #(
    parameter int COL_WIDTH  = 11,
    parameter int ACC_WIDTH  = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [4*COL_WIDTH-1:0]               psum_in,
    input  logic                                 psum_valid,
    output logic                                 psum_ready,
    input  logic [1:0]                           lane_mode,
    input  logic                                 psum_first,
    input  logic                                 psum_last,
    output logic [4*ACC_WIDTH-1:0]               out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic                                 err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state;
    logic [1:0]             mode_q, mode_eff;
    logic [ACC_WIDTH-1:0]   acc [4];
    logic [ACC_WIDTH-1:0]   ext [4];
    logic [ACC_WIDTH-1:0]   sum [4];
    logic [4*ACC_WIDTH-1:0] res;
    logic [4*ACC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   accept, bad_mode, enq, deq;

    assign psum_ready = fifo_count != CW'(FIFO_DEPTH);
    assign out_valid  = fifo_count != '0;
    assign out_data   = mem[rd_ptr];
    assign accept     = psum_valid && psum_ready;
    assign bad_mode   = psum_first && lane_mode == 2'd3;
    // A first beat decides its own mode; later beats use the mode latched with the group.
    assign mode_eff   = psum_first ? lane_mode : mode_q;
    assign enq        = accept && psum_last && !bad_mode && (psum_first || state == ACCUM);
    assign deq        = out_valid && out_ready;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [ACC_WIDTH-1:0] s0, s1, s2;
        assign s0 = ACC_WIDTH'($signed(psum_in[k*COL_WIDTH +: COL_WIDTH]));
        if (k < 2) begin : g_m1
            assign s1 = ACC_WIDTH'($signed(psum_in[k*2*COL_WIDTH +: 2*COL_WIDTH]));
        end else begin : g_m1z
            assign s1 = '0;
        end
        if (k == 0) begin : g_m2
            assign s2 = ACC_WIDTH'($signed(psum_in));
        end else begin : g_m2z
            assign s2 = '0;
        end
        assign ext[k] = mode_eff == 2'd0 ? s0 : mode_eff == 2'd1 ? s1 : mode_eff == 2'd2 ? s2 : '0;
        assign sum[k] = (psum_first ? '0 : acc[k]) + ext[k];
        assign res[k*ACC_WIDTH +: ACC_WIDTH] = sum[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= '0;
            err        <= 1'b0;
            acc        <= '{default: '0};
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                if (bad_mode) begin
                    err   <= 1'b1;
                    state <= IDLE;
                end else if (psum_first) begin
                    if (state == ACCUM) err <= 1'b1;
                    mode_q <= lane_mode;
                    acc    <= sum;
                    state  <= psum_last ? IDLE : ACCUM;
                end else if (state == IDLE) begin
                    err <= 1'b1;
                end else begin
                    acc <= sum;
                    if (psum_last) state <= IDLE;
                end
            end
            if (enq) begin
                mem[wr_ptr] <= res;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_bitfusion_psum_accum.sv
// tb_bitfusion_psum_accum: directed and random beats checked every cycle against a
// queue-based reference of group sums, plus literal results for the hand-worked cases.
module tb_bitfusion_psum_accum;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [43:0]  psum_in = '0;
    logic         psum_valid = 1'b0;
    logic         psum_ready;
    logic [1:0]   lane_mode = 2'd0;
    logic         psum_first = 1'b0;
    logic         psum_last = 1'b0;
    logic [191:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [2:0]   fifo_count;
    logic         err;

    bitfusion_psum_accum dut (
        .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .lane_mode(lane_mode), .psum_first(psum_first),
        .psum_last(psum_last), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .err(err)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    bit           open_m;
    bit           err_m;
    int           mode_m;
    logic [47:0]  acc_m [4];
    logic [191:0] q [$];

    function automatic void chk(string name, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endfunction

    // Value of lane k when the bus is read as (4 / 2 / 1) signed lanes of (11 / 22 / 44) bits.
    function automatic logic [47:0] lane_val(logic [43:0] b, int m, int k);
        int     w = m == 0 ? 11 : m == 1 ? 22 : 44;
        int     n = m == 0 ? 4 : m == 1 ? 2 : m == 2 ? 1 : 0;
        longint v;
        if (k >= n) return '0;
        v = longint'(b >> (k * w)) & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v -= longint'(1) << w;
        return v[47:0];
    endfunction

    function automatic logic [43:0] m0(int a, int b, int c, int d);
        return {d[10:0], c[10:0], b[10:0], a[10:0]};
    endfunction

    function automatic logic [43:0] m1(int a, int b);
        return {b[21:0], a[21:0]};
    endfunction

    function automatic void clear_model();
        open_m = 1'b0;
        err_m  = 1'b0;
        mode_m = 0;
        q.delete();
        for (int k = 0; k < 4; k++) acc_m[k] = '0;
    endfunction

    // Advance the reference by one clock using the inputs now on the pins, then compare.
    task automatic tick();
        bit a = psum_valid && q.size() < 4;
        bit d = out_ready && q.size() > 0;
        if (d) void'(q.pop_front());
        if (a) begin
            if (psum_first) begin
                if (open_m) err_m = 1'b1;
                if (lane_mode == 2'd3) begin
                    err_m  = 1'b1;
                    open_m = 1'b0;
                end else begin
                    mode_m = int'(lane_mode);
                    for (int k = 0; k < 4; k++) acc_m[k] = lane_val(psum_in, mode_m, k);
                    open_m = !psum_last;
                    if (psum_last) q.push_back({acc_m[3], acc_m[2], acc_m[1], acc_m[0]});
                end
            end else if (!open_m) begin
                err_m = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) acc_m[k] = acc_m[k] + lane_val(psum_in, mode_m, k);
                if (psum_last) begin
                    q.push_back({acc_m[3], acc_m[2], acc_m[1], acc_m[0]});
                    open_m = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("psum_ready", psum_ready, q.size() < 4);
        chk("out_valid", out_valid, q.size() > 0);
        chk("fifo_count", fifo_count, q.size());
        chk("err", err, err_m);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
    endtask

    task automatic send(logic [43:0] d, logic [1:0] m, bit f, bit l);
        bit took = 1'b0;
        psum_in = d; lane_mode = m; psum_first = f; psum_last = l; psum_valid = 1'b1;
        for (int i = 0; i < 100 && !took; i++) begin
            took = q.size() < 4;
            tick();
        end
        if (!took) chk("send_timeout", 1'b0, 1'b1);
        psum_valid = 1'b0;
    endtask

    task automatic idle(int n);
        psum_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        psum_valid = 1'b0;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_psum_ready", psum_ready, 1'b1);

        // Mode 0 single-beat group
        out_ready = 1'b1;
        send(m0(5, -1024, 1023, -1), 2'd0, 1, 1);
        chk("m0_single", out_data, {48'hFFFF_FFFF_FFFF, 48'd1023, 48'hFFFF_FFFF_FC00, 48'd5});
        idle(2);
        chk("m0_drained", fifo_count, 3'd0);

        // Mode 1 three-beat group
        send(m1(100, -2048), 2'd1, 1, 0);
        send(m1(-300, 2047), 2'd1, 0, 0);
        send(m1(7, 1), 2'd1, 0, 1);
        chk("m1_sum", out_data, {144'd0, 48'hFFFF_FFFF_FF3F});
        idle(3);

        // Backpressure: fifth beat stalls until the FIFO drains
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send(m0(v, 0, 0, 0), 2'd0, 1, 1);
        chk("bp_full_count", fifo_count, 3'd4);
        chk("bp_full_ready", psum_ready, 1'b0);
        psum_in = m0(5, 0, 0, 0); lane_mode = 2'd0; psum_first = 1; psum_last = 1; psum_valid = 1;
        tick();
        tick();
        chk("bp_stall_ready", psum_ready, 1'b0);
        chk("bp_head", out_data, 192'd1);
        out_ready = 1'b1;
        send(m0(5, 0, 0, 0), 2'd0, 1, 1);
        idle(8);
        chk("bp_empty", fifo_count, 3'd0);

        // Non-first beat while idle
        do_reset();
        send(m0(9, 0, 0, 0), 2'd0, 0, 1);
        idle(2);
        chk("idle_nonfirst_err", err, 1'b1);
        chk("idle_nonfirst_count", fifo_count, 3'd0);

        // Second first beat discards the open group
        do_reset();
        send(m0(5, 0, 0, 0), 2'd0, 1, 0);
        send(m0(7, 0, 0, 0), 2'd0, 1, 0);
        send(m0(2, 0, 0, 0), 2'd0, 0, 1);
        chk("refirst_sum", out_data, 192'd9);
        chk("refirst_err", err, 1'b1);
        idle(2);

        // Mode change mid-group is ignored
        do_reset();
        send(m0(3, 2, 0, 0), 2'd0, 1, 0);
        send(m0(-1, 1, 0, 0), 2'd2, 0, 1);
        chk("latch_sum", out_data, {96'd0, 48'd3, 48'd2});
        chk("latch_err", err, 1'b0);
        idle(2);

        // Mode 2 wrap: 40 * (2^43-1) mod 2^48
        send(44'h7FF_FFFF_FFFF, 2'd2, 1, 0);
        for (int i = 0; i < 38; i++) send(44'h7FF_FFFF_FFFF, 2'd2, 0, 0);
        send(44'h7FF_FFFF_FFFF, 2'd2, 0, 1);
        chk("wrap_sum", out_data, {144'd0, 48'h3FFF_FFFF_FFD8});
        idle(2);

        // Mode 3 on a first beat
        send(m0(4, 0, 0, 0), 2'd3, 1, 1);
        idle(2);
        chk("mode3_err", err, 1'b1);
        chk("mode3_count", fifo_count, 3'd0);

        // Async reset mid-group with two queued results
        do_reset();
        out_ready = 1'b0;
        send(m0(11, 0, 0, 0), 2'd0, 1, 1);
        send(m0(12, 0, 0, 0), 2'd0, 1, 1);
        send(m0(13, 0, 0, 0), 2'd0, 1, 0);
        chk("pre_rst_count", fifo_count, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_fifo_count", fifo_count, 3'd0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(m0(20, 0, 0, 0), 2'd0, 1, 0);
        send(m0(22, 0, 0, 0), 2'd0, 0, 1);
        chk("post_rst_sum", out_data, 192'd42);
        idle(2);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            psum_valid = ($urandom % 10) < 7;
            psum_in    = 44'({$urandom(), $urandom()});
            lane_mode  = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
            psum_first = ($urandom % 4) == 0;
            psum_last  = ($urandom % 3) == 0;
            out_ready  = ($urandom % 10) < 6;
            tick();
        end
        out_ready = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitfusion_psum_accum.md
Name: bitfusion_psum_accum

Overview:
- Sits directly downstream of the fusion-unit column; consumes the packed `psum_fwd` bus from the bottom of a column.
- Sign-extends each lane according to the active fusion mode and accumulates partial sums across K-tiles in wide per-lane accumulators.
- Pushes completed results into a small output FIFO with valid/ready handshakes on both sides.

Parameters:
- COL_WIDTH, 11, width of one packed psum lane (2b-parallelism lane); input bus is 4*COL_WIDTH.
- ACC_WIDTH, 48, per-lane accumulator width; must be >= 4*COL_WIDTH.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- psum_in  in  4*COL_WIDTH  packed partial sums from the column (lane0 = LSBs).
- psum_valid  in  1  beat present on psum_in.
- psum_ready  out  1  block accepts a beat this cycle.
- lane_mode  in  2  0 = 4 lanes x COL_WIDTH, 1 = 2 lanes x 2*COL_WIDTH, 2 = 1 lane x 4*COL_WIDTH, 3 = reserved.
- psum_first  in  1  beat opens a new accumulation group.
- psum_last  in  1  beat closes the group; result is enqueued.
- out_data  out  4*ACC_WIDTH  result; lane k in bits [k*ACC_WIDTH +: ACC_WIDTH].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release):
  - FSM enters IDLE; accumulators, FIFO pointers and latched mode are cleared.
  - Output values: out_valid=0, out_data=0, fifo_count=0, err=0, psum_ready=1.
- Accept: a beat is accepted when psum_valid && psum_ready.
- psum_ready:
  - psum_ready = !(fifo_count==FIFO_DEPTH).
  - It is combinational from registered state only and never depends on psum_valid.
  - When the FIFO is full, all beats stall, not only last beats.
- FSM states: IDLE (no open group) and ACCUM (group open).
  - IDLE, accepted beat with first=1: load the accumulators with the extended lanes. If last=0, go to ACCUM; if last=1, enqueue the loaded value and stay in IDLE.
  - IDLE, accepted beat with first=0: beat is dropped, err<=1.
  - ACCUM, accepted beat with first=0: acc += extended lanes. If last=1, enqueue the sum and go to IDLE.
  - ACCUM, accepted beat with first=1: the open group is discarded (not enqueued), err<=1, and the beat is handled as the IDLE first-beat case.
- Mode latch:
  - lane_mode is latched on the first beat of each group; lane_mode changes mid-group are ignored.
  - lane_mode=3 on a first beat: err<=1, the beat and the group are dropped, and the FSM stays in or returns to IDLE.
- Lane extension:
  - Mode 0: lane k = sign-extend psum_in[k*COL_WIDTH +: COL_WIDTH], k=0..3.
  - Mode 1: lane j = sign-extend psum_in[j*2*COL_WIDTH +: 2*COL_WIDTH], j=0..1; lanes 2 and 3 are forced to 0.
  - Mode 2: lane 0 = sign-extend the full bus; lanes 1..3 are forced to 0.
- Arithmetic: two's-complement, modulo 2^ACC_WIDTH wrap, no saturation, no overflow flag.
- FIFO behaviour:
  - First-word registered: out_valid rises the cycle after a last beat is accepted into an empty FIFO (latency 1).
  - Dequeue on out_valid && out_ready.
  - Simultaneous enqueue and dequeue while full or non-empty: count unchanged, order preserved.
  - out_data holds its value while out_valid && !out_ready.
  - out_data is don't-care while out_valid=0.
- err: set only by the events above; cleared only by reset.
- Reset mid-group: the partial group is lost and no result is emitted.

Test Plan:
- Mode 0, single-beat group (first=last=1) with lanes {lane3..0} = {-1, 1023, -1024, 5}, out_ready=1 → one cycle later out_valid=1 and lanes = {-1, 1023, -1024, 5} sign-extended to 48b; fifo_count returns to 0 after the pop.
- Mode 1, three-beat group with lane0 = 100, -300, 7 and lane1 = -2048, 2047, 1 → single result with lane0=-193, lane1=0, lanes2/3=0; exactly one out_valid pulse.
- Backpressure: out_ready=0, push five single-beat groups of values 1..5 with FIFO_DEPTH=4 → psum_ready drops after the 4th; the 5th beat stalls with its inputs held; raising out_ready drains 1,2,3,4,5 in order with no loss or duplicates.
- Protocol errors, each after a reset:
  - A beat with first=0 in IDLE → dropped, no output, err=1.
  - In a separate run, a second first beat inside an open group → the old group is discarded and only the new group's sum is emitted.
- Mode latch and wrap:
  - Change lane_mode 0→2 mid-group → accumulation continues in mode 0.
  - In mode 2, accumulate 2^43-1 repeatedly until the 48b sum wraps → result is the modulo-2^48 value.
- Async reset: assert rst_n=0 mid-group while the FIFO holds 2 entries → out_valid and fifo_count go to 0 immediately, before the next clock edge; the subsequent clean group yields only its own sum.
